// File: rtl/mul10_sequencer.sv
// Shift-and-add multiply sequencer for the 10-bit ALU.
// Steps an external ripple-carry adder through WIDTH iterations and
// accumulates a 2*WIDTH-bit unsigned product in {acc_hi, acc_lo}.
module mul10_sequencer #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // State register; reset mid-RUN simply drops back to IDLE with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake outputs and adder operand selection.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        add_a = acc_hi;
        // Multiplier LSB gates whether the multiplicand is added this step.
        add_b = acc_lo[0] ? mcand : '0;
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start seen here is taken immediately for back-to-back products.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, then one shift-and-add step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= op_a;
      acc_hi <= '0;
      acc_lo <= op_b;
    end else if (state == RUN) begin
      // The adder carry-out becomes the new MSB, so the shift never overflows.
      cnt                    <= cnt + 1'b1;
      {acc_hi, acc_lo}       <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
    end
  end

  assign product = {acc_hi, acc_lo};

endmodule
